// File: rtl/bcd_counter_n.sv
// rtl/bcd_counter_n.sv - DIGITS-wide cascaded BCD up/down counter with registered wrap flag
// Optional parallel load with per-digit clamp: define BCD_COUNTER_LOAD_EN.
module bcd_counter_n #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
`ifdef BCD_COUNTER_LOAD_EN
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
`endif
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic [W-1:0] step_val;
  logic         all_nine, all_zero;

  // Digit i moves only when every lower digit is at its rollover value.
  always_comb begin
    logic run_c;
    logic run_b;
    run_c    = 1'b1;
    run_b    = 1'b1;
    step_val = q_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (up) begin
        if (run_c) begin
          step_val[4*i +: 4] = (q_q[4*i +: 4] == 4'd9) ? 4'd0 : q_q[4*i +: 4] + 4'd1;
        end
      end else begin
        if (run_b) begin
          step_val[4*i +: 4] = (q_q[4*i +: 4] == 4'd0) ? 4'd9 : q_q[4*i +: 4] - 4'd1;
        end
      end
      run_c = run_c & (q_q[4*i +: 4] == 4'd9);
      run_b = run_b & (q_q[4*i +: 4] == 4'd0);
    end
    all_nine = run_c;
    all_zero = run_b;
  end

`ifdef BCD_COUNTER_LOAD_EN
  logic [W-1:0] load_val;

  always_comb begin
    load_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_val[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
    end
  end
`endif

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
`ifdef BCD_COUNTER_LOAD_EN
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d  = step_val;
      tc_d = up ? all_nine : all_zero;
    end
`else
    if (en) begin
      q_d  = step_val;
      tc_d = up ? all_nine : all_zero;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb/tb_bcd_counter_n.sv - scoreboard bench for bcd_counter_n at DIGITS 1..4
// Load scenarios run only when BCD_COUNTER_LOAD_EN is defined.
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic [4:1]  rst_v = 4'hF;
  logic [4:1]  en_v  = 4'h0;
  logic [4:1]  up_v  = 4'hF;
  logic [4:1]  ld_v  = 4'h0;
  logic [31:0] din_v = '0;
  logic [3:0]  q1;
  logic [7:0]  q2;
  logic [11:0] q3;
  logic [15:0] q4;
  logic [4:1]  tc_v;

  int errors = 0;
  int checks = 0;
  int m [1:4] = '{0, 0, 0, 0};
  logic [31:0] exp_q  [$];
  logic        exp_tc [$];

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up(up_v[1]),
`ifdef BCD_COUNTER_LOAD_EN
    .load(ld_v[1]), .din(din_v[3:0]),
`endif
    .q(q1), .tc(tc_v[1]));
  bcd_counter_n #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst_v[2]), .en(en_v[2]), .up(up_v[2]),
`ifdef BCD_COUNTER_LOAD_EN
    .load(ld_v[2]), .din(din_v[7:0]),
`endif
    .q(q2), .tc(tc_v[2]));
  bcd_counter_n #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst_v[3]), .en(en_v[3]), .up(up_v[3]),
`ifdef BCD_COUNTER_LOAD_EN
    .load(ld_v[3]), .din(din_v[11:0]),
`endif
    .q(q3), .tc(tc_v[3]));
  bcd_counter_n #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst_v[4]), .en(en_v[4]), .up(up_v[4]),
`ifdef BCD_COUNTER_LOAD_EN
    .load(ld_v[4]), .din(din_v[15:0]),
`endif
    .q(q4), .tc(tc_v[4]));

  function automatic logic [31:0] to_bcd(input int n, input int d);
    logic [31:0] v;
    int k;
    v = '0;
    k = n;
    for (int i = 0; i < d; i++) begin
      v[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return v;
  endfunction

  function automatic int clamp_to_int(input logic [31:0] dv, input int d);
    int n;
    int dg;
    n = 0;
    for (int i = d - 1; i >= 0; i--) begin
      dg = int'(dv[4*i +: 4]);
      if (dg > 9) dg = 9;
      n = n * 10 + dg;
    end
    return n;
  endfunction

  // Drives one edge on counter d, pushes the model's prediction, returns the DUT's output.
  task automatic step(input int d, input bit r, input bit e, input bit u, input bit ld,
                      input logic [31:0] dv, output logic [31:0] aq, output logic atc);
    int modv;
    logic et;
    modv = 10 ** d;
    if (!r) begin
      m[d] = 0; et = 1'b0;
    end else if (ld) begin
      m[d] = clamp_to_int(dv, d); et = 1'b0;
    end else if (e) begin
      if (u) begin
        et = (m[d] == modv - 1); m[d] = (m[d] + 1) % modv;
      end else begin
        et = (m[d] == 0); m[d] = (m[d] + modv - 1) % modv;
      end
    end else begin
      et = 1'b0;
    end
    exp_q.push_back(to_bcd(m[d], d));
    exp_tc.push_back(et);
    rst_v = 4'hF; en_v = 4'h0; ld_v = 4'h0;
    rst_v[d] = r; en_v[d] = e; up_v[d] = u; ld_v[d] = ld; din_v = dv;
    @(posedge clk);
    #1;
    case (d)
      1: aq = {28'b0, q1};
      2: aq = {24'b0, q2};
      3: aq = {20'b0, q3};
      default: aq = {16'b0, q4};
    endcase
    atc = tc_v[d];
  endtask

  task automatic test_reset;
    logic [31:0] aq, eq;
    logic atc, et;
    for (int i = 0; i < 2; i++) begin
      step(2, 1'b0, 1'b0, 1'b1, 1'b0, '0, aq, atc);
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL reset_q got %h exp %h", aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL reset_tc got %b exp %b", atc, et); end
    end
  endtask

  task automatic test_up_wrap;
    logic [31:0] aq, eq;
    logic atc, et;
    for (int i = 0; i < 100; i++) begin
      step(2, 1'b1, 1'b1, 1'b1, 1'b0, '0, aq, atc);
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL up2_q step %0d got %h exp %h", i, aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL up2_tc step %0d got %b exp %b", i, atc, et); end
    end
  endtask

  task automatic test_down_wrap;
    logic [31:0] aq, eq;
    logic atc, et;
    for (int i = 0; i < 3; i++) begin
      step(2, (i != 0), 1'b1, 1'b0, 1'b0, '0, aq, atc);
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL down2_q step %0d got %h exp %h", i, aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL down2_tc step %0d got %b exp %b", i, atc, et); end
    end
  endtask

  task automatic test_enable_dir;
    logic [31:0] aq, eq;
    logic atc, et;
    for (int i = 0; i < 26; i++) begin
      if (i == 0)       step(3, 1'b0, 1'b0, 1'b1, 1'b0, '0, aq, atc);
      else if (i < 20)  step(3, 1'b1, 1'b1, 1'b1, 1'b0, '0, aq, atc);
      else if (i < 25)  step(3, 1'b1, 1'b0, 1'b1, 1'b0, '0, aq, atc);
      else              step(3, 1'b1, 1'b1, 1'b0, 1'b0, '0, aq, atc);
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL endir3_q step %0d got %h exp %h", i, aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL endir3_tc step %0d got %b exp %b", i, atc, et); end
    end
    checks++;
    if (q3 !== 12'h018) begin errors++; $display("FAIL endir3_final got %h exp 018", q3); end
  endtask

  task automatic test_wide_wrap;
    logic [31:0] aq, eq;
    logic atc, et;
    // reset, down-wrap to 9999, up-wrap to 0000, down-wrap again with reset on that edge
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: step(4, 1'b0, 1'b0, 1'b1, 1'b0, '0, aq, atc);
        1: step(4, 1'b1, 1'b1, 1'b0, 1'b0, '0, aq, atc);
        2: step(4, 1'b1, 1'b1, 1'b1, 1'b0, '0, aq, atc);
        3: step(4, 1'b0, 1'b1, 1'b0, 1'b0, '0, aq, atc);
        default: step(4, 1'b1, 1'b1, 1'b0, 1'b0, '0, aq, atc);
      endcase
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL wrap4_q step %0d got %h exp %h", i, aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL wrap4_tc step %0d got %b exp %b", i, atc, et); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] aq, eq;
    logic atc, et;
    for (int i = 0; i < 26; i++) begin
      if (i == 0)      step(1, 1'b0, 1'b0, 1'b1, 1'b0, '0, aq, atc);
      else if (i < 22) step(1, 1'b1, 1'b1, 1'b1, 1'b0, '0, aq, atc);
      else             step(1, 1'b1, 1'b1, i[0], 1'b0, '0, aq, atc);
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL b2b1_q step %0d got %h exp %h", i, aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL b2b1_tc step %0d got %b exp %b", i, atc, et); end
    end
  endtask

`ifdef BCD_COUNTER_LOAD_EN
  task automatic test_load;
    logic [31:0] aq, eq;
    logic atc, et;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: step(4, 1'b0, 1'b0, 1'b1, 1'b0, '0, aq, atc);
        1: step(4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h9A3F, aq, atc);
        2: step(4, 1'b1, 1'b1, 1'b1, 1'b0, '0, aq, atc);
        3: step(4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h9999, aq, atc);
        4: step(4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, aq, atc);
        5: step(4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h9999, aq, atc);
        default: step(4, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1FB2, aq, atc);
      endcase
      eq = exp_q.pop_front(); et = exp_tc.pop_front(); checks += 2;
      if (aq !== eq) begin errors++; $display("FAIL load4_q step %0d got %h exp %h", i, aq, eq); end
      if (atc !== et) begin errors++; $display("FAIL load4_tc step %0d got %b exp %b", i, atc, et); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_enable_dir();
    test_wide_wrap();
    test_back_to_back();
`ifdef BCD_COUNTER_LOAD_EN
    test_load();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
